demux1x2_stream: RTL
====================

// Module: demux1x2_stream
// PURPOSE
//  1-to-2 registered stream demultiplexer; the inverse of the 2:1 datapath mux.
//  - A single valid/ready input stream carries a per-word select bit.
//  - Each word goes to lane A (sel=0) or lane B (sel=1).
//  - Each lane has its own 2-entry FIFO, so a stalled lane does not drop data
//    and an idle lane runs at full throughput.
//  - Sits between a shared producer and two consumer datapaths.
// PARAMETERS
//  DATAWIDTH  64  width of in_data, a_data, b_data (bits)
// PORTS
//  Clk       in   1          clock; all state changes on rising edge
//  Rst       in   1          synchronous, active-high reset
//  in_valid  in   1          input word present
//  in_ready  out  1          input word accepted this cycle when in_valid & in_ready
//  in_data   in   DATAWIDTH  input word
//  in_sel    in   1          destination: 0 -> lane A, 1 -> lane B
//  a_valid   out  1          lane A head word valid
//  a_ready   in   1          lane A consumer accepts head word
//  a_data    out  DATAWIDTH  lane A head word
//  b_valid   out  1          lane B head word valid
//  b_ready   in   1          lane B consumer accepts head word
//  b_data    out  DATAWIDTH  lane B head word
// BEHAVIOUR
//  - One clock (Clk); reset is synchronous and active-high (Rst), sampled on the rising edge.
//  - Reset values: a_valid=b_valid=0, a_data=b_data=0, both lane counts=0.
//    in_ready=1 after reset (both lanes empty).
//  - Reset mid-operation flushes both FIFOs. Buffered words are discarded and no
//    output handshake completes in the reset cycle.
//  - Input protocol: once in_valid=1, in_valid, in_data and in_sel hold stable
//    until accepted. A bench assertion checks this; the RTL does not.
//  - in_ready = (in_sel==0) ? (countA<2) : (countB<2).
//    It is combinational from in_sel and registered counts only. There is no
//    path from a_ready/b_ready to in_ready.
//  - Push: in_valid & in_ready writes in_data into the selected lane's tail.
//  - Pop: x_valid & x_ready removes the lane head. x_valid = (countX!=0).
//    x_data is the head word and is held stable while x_valid & !x_ready.
//  - Latency: a word accepted at edge N is visible on x_valid/x_data after edge N
//    (1 cycle). No combinational in->out path.
//  - Per-lane count update:
//    - push only: +1
//    - pop only: -1
//    - push and pop in the same cycle: unchanged, the new word is queued behind the head.
//  - Full lane (count=2): in_ready=0 for words selecting that lane, even if that
//    lane's pop occurs the same cycle. Depth 2 still sustains 1 word/cycle.
//  - Head-of-line blocking: a stalled word for a full lane blocks later words for
//    the other lane. Order is preserved per lane. No global ordering across lanes.
//  - Per lane, words are never dropped, duplicated or reordered.
//  - FIFO storage: 2 entries, 1-bit rd/wr pointers that wrap 1->0, and a 2-bit
//    count. Empty = count==0, full = count==2.
// STRUCTURE
//  - Shared package/include: DEMUX_LANE_DEPTH=2, LANE_A=1'b0, LANE_B=1'b1.
//  - Sub-module demux_lane_fifo #(DATAWIDTH): push/din/full, pop/dout/empty, Clk, Rst.
//    Instantiated twice.
//  - Top: steering decode of in_sel to push_a/push_b, and the in_ready mux.
// TESTING
//  1. Reset: assert Rst 2 cycles mid-traffic with both lanes holding data
//     -> next cycle a_valid=b_valid=0, data=0, in_ready=1.
//  2. Steering: send 0x11 (sel0), 0x22 (sel1), 0x33 (sel0) with a_ready=b_ready=1
//     -> lane A gets 0x11 then 0x33, lane B gets 0x22. Each appears 1 cycle after accept.
//  3. Backpressure/full: a_ready=0, push 0xA0, 0xA1, 0xA2 to A
//     -> 0xA0 and 0xA1 accepted, in_ready=0 for 0xA2. a_data holds 0xA0.
//     Raise a_ready -> 0xA0, 0xA1, 0xA2 drain in order.
//  4. Head-of-line: lane A full and stalled, present a sel=1 word behind a blocked sel=0 word
//     -> B receives nothing until A pops. Then order is preserved.
//  5. Throughput: 100 words alternating sel with both readies=1
//     -> 1 accept per cycle, no bubbles. Per-lane scoreboard matches exactly.
//  6. Simultaneous push+pop with count=1 on a lane
//     -> count stays 1, head advances to the new word next cycle.

Source files
------------

// File: rtl/demux1x2_stream_pkg.sv
// Shared definitions for the 1-to-2 stream demultiplexer.
//   DEMUX_LANE_DEPTH : entries per lane FIFO
//   LANE_A / LANE_B  : in_sel encodings for the two destination lanes
//   lane_cnt_t       : per-lane occupancy count (0..DEMUX_LANE_DEPTH)
//   lane_full()      : occupancy-to-full helper shared by FIFO and top
package demux1x2_stream_pkg;

  localparam int DEMUX_LANE_DEPTH = 2;

  localparam logic LANE_A = 1'b0;
  localparam logic LANE_B = 1'b1;

  typedef logic [1:0] lane_cnt_t;

  function automatic logic lane_full(input lane_cnt_t cnt);
    return (cnt == lane_cnt_t'(DEMUX_LANE_DEPTH));
  endfunction

endpackage

// File: rtl/demux1x2_stream_if.sv
// Bundle of all stream signals around the demultiplexer.
//   in_*     : shared producer stream (valid/ready/data + per-word select)
//   a_*, b_* : the two consumer lanes (valid/ready/data)
//   a_count, b_count : lane occupancy, exported for observation only
// Handshake rule for every stream here: a word transfers on a rising clock edge
// where valid & ready are both 1; once valid is raised, the source keeps valid,
// data (and in_sel) unchanged until that transfer happens.
// modport slave  : the demultiplexer
// modport master : the environment (producer + both consumers)
interface demux1x2_stream_if
  import demux1x2_stream_pkg::*;
#(
  parameter int DATAWIDTH = 64
);

  logic                 in_valid;
  logic                 in_ready;
  logic [DATAWIDTH-1:0] in_data;
  logic                 in_sel;

  logic                 a_valid;
  logic                 a_ready;
  logic [DATAWIDTH-1:0] a_data;

  logic                 b_valid;
  logic                 b_ready;
  logic [DATAWIDTH-1:0] b_data;

  lane_cnt_t            a_count;
  lane_cnt_t            b_count;

  modport slave (
    input  in_valid, in_data, in_sel, a_ready, b_ready,
    output in_ready, a_valid, a_data, b_valid, b_data, a_count, b_count
  );

  modport master (
    output in_valid, in_data, in_sel, a_ready, b_ready,
    input  in_ready, a_valid, a_data, b_valid, b_data, a_count, b_count
  );

endinterface

// File: rtl/demux_lane_fifo.sv
// Two-entry FIFO used as the buffer of one demultiplexer lane.
//   Clk, Rst    : clock, synchronous active-high reset (flushes all contents)
//   push, din   : write din at the tail (ignored when full)
//   full        : count == 2
//   pop, dout   : remove the head; dout is always the head entry
//   empty       : count == 0
//   count       : current occupancy
// Storage is indexed by 1-bit read/write pointers that wrap 1 -> 0; the 2-bit
// count disambiguates full from empty when the pointers are equal.
module demux_lane_fifo
  import demux1x2_stream_pkg::*;
#(
  parameter int DATAWIDTH = 64
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 push,
  input  logic [DATAWIDTH-1:0] din,
  output logic                 full,
  input  logic                 pop,
  output logic [DATAWIDTH-1:0] dout,
  output logic                 empty,
  output lane_cnt_t            count
);

  logic [DATAWIDTH-1:0] mem_q [DEMUX_LANE_DEPTH];
  logic [DATAWIDTH-1:0] mem_d [DEMUX_LANE_DEPTH];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  lane_cnt_t            count_q, count_d;

  logic do_push;
  logic do_pop;

  assign full  = lane_full(count_q);
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    // A full FIFO refuses a push even if it pops this cycle; the top never
    // offers one, this just keeps the storage safe.
    do_push = push && !full;
    do_pop  = pop && !empty;

    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    // Push and pop together leave the count unchanged: the new word lands
    // behind the head while the head advances.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      // Storage is cleared too so the lane data outputs read zero after reset.
      for (int i = 0; i < DEMUX_LANE_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/demux1x2_stream.sv
// 1-to-2 registered stream demultiplexer.
//   Clk, Rst : clock, synchronous active-high reset
//   bus      : slave side of demux1x2_stream_if
//              in_valid/in_ready/in_data/in_sel -> steered by in_sel
//              a_valid/a_ready/a_data            <- lane A (in_sel = 0)
//              b_valid/b_ready/b_data            <- lane B (in_sel = 1)
//              a_count/b_count                   <- lane occupancies
// Each lane owns a 2-entry FIFO, so a word accepted on one edge is visible on
// its lane right after that edge, and a stalled lane never loses data.
// in_ready depends only on in_sel and the registered lane counts; consumer
// readies never reach it combinationally. A word for a full lane therefore
// blocks every later word, including words for the other lane.
module demux1x2_stream
  import demux1x2_stream_pkg::*;
#(
  parameter int DATAWIDTH = 64
) (
  input  logic                     Clk,
  input  logic                     Rst,
  demux1x2_stream_if.slave         bus
);

  logic      a_full, a_empty, push_a, pop_a;
  logic      b_full, b_empty, push_b, pop_b;
  lane_cnt_t a_cnt, b_cnt;
  logic      accept;

  // Readiness is judged for the selected lane only, before any pop this cycle.
  assign bus.in_ready = (bus.in_sel == LANE_A) ? !a_full : !b_full;
  assign accept       = bus.in_valid && bus.in_ready;

  assign push_a = accept && (bus.in_sel == LANE_A);
  assign push_b = accept && (bus.in_sel == LANE_B);

  assign pop_a = bus.a_valid && bus.a_ready;
  assign pop_b = bus.b_valid && bus.b_ready;

  assign bus.a_valid = !a_empty;
  assign bus.b_valid = !b_empty;
  assign bus.a_count = a_cnt;
  assign bus.b_count = b_cnt;

  demux_lane_fifo #(.DATAWIDTH(DATAWIDTH)) u_lane_a (
    .Clk   (Clk),
    .Rst   (Rst),
    .push  (push_a),
    .din   (bus.in_data),
    .full  (a_full),
    .pop   (pop_a),
    .dout  (bus.a_data),
    .empty (a_empty),
    .count (a_cnt)
  );

  demux_lane_fifo #(.DATAWIDTH(DATAWIDTH)) u_lane_b (
    .Clk   (Clk),
    .Rst   (Rst),
    .push  (push_b),
    .din   (bus.in_data),
    .full  (b_full),
    .pop   (pop_b),
    .dout  (bus.b_data),
    .empty (b_empty),
    .count (b_cnt)
  );

endmodule
